// File: rtl/priority_decoder_pkg.sv
// Shared types and helpers for the priority decoder and its companion encoder bench.
package priority_decoder_pkg;

    // Two-state control: waiting for a code, or holding a decoded line.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Encoded request codes as produced by the 4-input priority encoder.
    localparam logic [1:0] CODE_D0 = 2'b00;
    localparam logic [1:0] CODE_D1 = 2'b01;
    localparam logic [1:0] CODE_D2 = 2'b10;
    localparam logic [1:0] CODE_D3 = 2'b11;

    // Hold window counter width; bounds HOLD_CYCLES to 1..255.
    localparam int HOLD_W = 8;

    // Expand a 2-bit code into its one-hot line vector {d3,d2,d1,d0}.
    function automatic logic [3:0] code_to_onehot(input logic [1:0] code);
        logic [3:0] onehot;
        case (code)
            CODE_D0: onehot = 4'b0001;
            CODE_D1: onehot = 4'b0010;
            CODE_D2: onehot = 4'b0100;
            CODE_D3: onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/priority_decoder_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clr/rst zero it.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    // Advance by one unless already at the ceiling; the ceiling is held, never wrapped.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] val);
        return (val == MAX) ? MAX : val + ONE;
    endfunction

    // Clear takes priority over a coincident increment so the cleared value is exact.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= sat_inc(q);
        end
    end

endmodule

// File: rtl/priority_decoder.sv
// Registered 2-to-4 decoder for priority-encoder codes with a programmable
// hold window per decoded line and per-line saturating event counters.
module priority_decoder
    import priority_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             v,
    input  logic             clr_cnt,
    output logic             in_ready,
    output logic             d0,
    output logic             d1,
    output logic             d2,
    output logic             d3,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("priority_decoder: HOLD_CYCLES must be in 1..255");
    end

    // The window counts down from HOLD_CYCLES-1 to 0, so the line is up for
    // exactly HOLD_CYCLES cycles including the one right after the accept.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [3:0]        line_q;     // latched code, kept directly in one-hot form
    logic              ready_q;
    logic              valid_q;
    logic              accept;
    logic [3:0]        line_inc;
    logic [CNT_W-1:0]  cnt_q [4];

    // A code is taken only when the decoder is advertising readiness.
    assign accept   = v & ready_q;
    assign line_inc = accept ? code_to_onehot({a, b}) : 4'b0000;

    // Control FSM: all outputs are registered so nothing leaks combinationally from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            line_q   <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_LOAD;
                        line_q   <= code_to_onehot({a, b});
                        ready_q  <= 1'b0;
                        valid_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state   <= IDLE;
                        line_q  <= '0;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    line_q  <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // One diagnostic counter per decoded line, bumped on the accept edge.
    for (genvar i = 0; i < 4; i++) begin : g_cnt
        sat_counter #(
            .W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr_cnt),
            .inc (line_inc[i]),
            .q   (cnt_q[i])
        );
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign d0        = line_q[0];
    assign d1        = line_q[1];
    assign d2        = line_q[2];
    assign d3        = line_q[3];
    assign cnt0      = cnt_q[0];
    assign cnt1      = cnt_q[1];
    assign cnt2      = cnt_q[2];
    assign cnt3      = cnt_q[3];

endmodule

// File: tb/tb_priority_decoder.sv
// Self-checking bench for priority_decoder: a wide-counter instance with a
// 4-cycle hold window and a 2-bit-counter instance with a 1-cycle window.
module tb_priority_decoder;

    localparam int H_A  = 4;
    localparam int CW_A = 8;
    localparam int H_B  = 1;
    localparam int CW_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic            rst, a, b, v, clr_cnt;
    logic            in_ready, d0, d1, d2, d3, out_valid;
    logic [CW_A-1:0] cnt0, cnt1, cnt2, cnt3;

    // Instance B signals
    logic            rst_s, a_s, b_s, v_s, clr_s;
    logic            in_ready_s, d0_s, d1_s, d2_s, d3_s, out_valid_s;
    logic [CW_B-1:0] cnt0_s, cnt1_s, cnt2_s, cnt3_s;

    priority_decoder #(.HOLD_CYCLES(H_A), .CNT_W(CW_A)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .v(v), .clr_cnt(clr_cnt),
        .in_ready(in_ready), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .out_valid(out_valid), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    priority_decoder #(.HOLD_CYCLES(H_B), .CNT_W(CW_B)) dut_s (
        .clk(clk), .rst(rst_s), .a(a_s), .b(b_s), .v(v_s), .clr_cnt(clr_s),
        .in_ready(in_ready_s), .d0(d0_s), .d1(d1_s), .d2(d2_s), .d3(d3_s),
        .out_valid(out_valid_s), .cnt0(cnt0_s), .cnt1(cnt1_s), .cnt2(cnt2_s), .cnt3(cnt3_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboards: A holds full expected output vectors, B holds expected cnt3 values.
    logic [37:0]     sb_a [$];
    logic [CW_B-1:0] sb_b [$];

    // Reference model state for instance A
    bit m_idle = 1'b1;
    int m_left = 0;
    int m_line = 0;
    int m_cnt [4] = '{0, 0, 0, 0};
    bit m_acc = 1'b0;

    function automatic logic [37:0] obs_a();
        return {in_ready, out_valid, d3, d2, d1, d0, cnt3, cnt2, cnt1, cnt0};
    endfunction

    // Advance the model by one clock edge with the given inputs and queue the expected outputs.
    task automatic model_a(input logic r, input logic aa, input logic bb, input logic vv, input logic cc);
        logic [37:0] e;
        logic [3:0]  dv;
        m_acc = 1'b0;
        if (r) begin
            m_idle = 1'b1;
            m_left = 0;
            m_line = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            if (m_idle) begin
                if (vv) begin
                    m_acc  = 1'b1;
                    m_idle = 1'b0;
                    m_left = H_A - 1;
                    m_line = {30'd0, aa, bb};
                end
            end else if (m_left == 0) begin
                m_idle = 1'b1;
            end else begin
                m_left = m_left - 1;
            end
            if (cc) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (m_acc && m_cnt[m_line] < (1 << CW_A) - 1) begin
                m_cnt[m_line] = m_cnt[m_line] + 1;
            end
        end
        dv = m_idle ? 4'b0000 : 4'(1 << m_line);
        e  = {m_idle, ~m_idle, dv, 8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
        sb_a.push_back(e);
    endtask

    // Drive instance A away from the edge, record the expectation, then wait past the edge.
    task automatic step_a(input logic r, input logic aa, input logic bb, input logic vv, input logic cc);
        @(negedge clk);
        rst = r; a = aa; b = bb; v = vv; clr_cnt = cc;
        model_a(r, aa, bb, vv, cc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [37:0] exp;
        rst_s = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sb_a.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL reset_hold[%0d] got=%h exp=%h", i, obs_a(), exp);
            else n_pass++;
        end
        rst_s = 1'b0;
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb_a.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL reset_release got=%h exp=%h", obs_a(), exp);
        else n_pass++;
        n_checks++;
        if ({in_ready, out_valid, d3, d2, d1, d0, cnt3, cnt2, cnt1, cnt0} !== {1'b1, 37'd0})
            $display("FAIL reset_state got=%h exp=%h", obs_a(), {1'b1, 37'd0});
        else n_pass++;
        n_checks++;
        if ({in_ready_s, out_valid_s, d3_s, d2_s, d1_s, d0_s, cnt3_s, cnt2_s, cnt1_s, cnt0_s} !== {1'b1, 13'd0})
            $display("FAIL reset_state_s got=%b exp=%b",
                     {in_ready_s, out_valid_s, d3_s, d2_s, d1_s, d0_s, cnt3_s, cnt2_s, cnt1_s, cnt0_s}, {1'b1, 13'd0});
        else n_pass++;
    endtask

    task automatic test_single_decode();
        logic [37:0] exp;
        int d2_hi = 0;
        int rdy_lo = 0;
        step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sb_a.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL single[%0d] got=%h exp=%h", i, obs_a(), exp);
            else n_pass++;
            if (d2 === 1'b1) d2_hi++;
            if (in_ready === 1'b0) rdy_lo++;
        end
        n_checks++;
        if (d2_hi !== 4 || rdy_lo !== 4) $display("FAIL single_width d2_hi=%0d rdy_lo=%0d exp=4/4", d2_hi, rdy_lo);
        else n_pass++;
        n_checks++;
        if ({cnt3, cnt2, cnt1, cnt0} !== {8'd0, 8'd1, 8'd0, 8'd0})
            $display("FAIL single_counts got=%h exp=%h", {cnt3, cnt2, cnt1, cnt0}, {8'd0, 8'd1, 8'd0, 8'd0});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [37:0] exp;
        logic [1:0]  codes [3];
        logic [1:0]  c;
        bit          taken;
        codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b11;
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp = sb_a.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL b2b_clear got=%h exp=%h", obs_a(), exp);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            c = codes[k];
            taken = 1'b0;
            for (int t = 0; t < 12 && !taken; t++) begin
                step_a(1'b0, c[1], c[0], 1'b1, 1'b0);
                taken = m_acc;
                exp = sb_a.pop_front();
                n_checks++;
                if (obs_a() !== exp) $display("FAIL b2b[%0d.%0d] got=%h exp=%h", k, t, obs_a(), exp);
                else n_pass++;
            end
            if (!taken) begin
                n_checks++;
                $display("FAIL b2b_timeout code=%b got=not_accepted exp=accepted", c);
            end
        end
        for (int i = 0; i < H_A + 1; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sb_a.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL b2b_drain[%0d] got=%h exp=%h", i, obs_a(), exp);
            else n_pass++;
        end
        n_checks++;
        if ({cnt3, cnt2, cnt1, cnt0} !== {8'd1, 8'd0, 8'd1, 8'd1})
            $display("FAIL b2b_counts got=%h exp=%h", {cnt3, cnt2, cnt1, cnt0}, {8'd1, 8'd0, 8'd1, 8'd1});
        else n_pass++;
    endtask

    task automatic test_clear_priority();
        logic [37:0] exp;
        step_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        exp = sb_a.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL clr_accept got=%h exp=%h", obs_a(), exp);
        else n_pass++;
        n_checks++;
        if ({d3, d2, d1, d0, cnt1, cnt0, cnt3} !== {4'b0010, 24'd0})
            $display("FAIL clr_wins got=%h exp=%h", {d3, d2, d1, d0, cnt1, cnt0, cnt3}, {4'b0010, 24'd0});
        else n_pass++;
        for (int i = 0; i < H_A; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            exp = sb_a.pop_front();
            n_checks++;
            if (obs_a() !== exp) $display("FAIL clr_drain[%0d] got=%h exp=%h", i, obs_a(), exp);
            else n_pass++;
        end
        // Accept code 10, then reset during the second hold cycle.
        step_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp = sb_a.pop_front();
            if (i == 2) begin
                n_checks++;
                if (obs_a() !== exp) $display("FAIL rst_mid_hold got=%h exp=%h", obs_a(), exp);
                else n_pass++;
            end
        end
        n_checks++;
        if ({in_ready, out_valid, d3, d2, d1, d0} !== 6'b100000)
            $display("FAIL rst_drop got=%b exp=%b", {in_ready, out_valid, d3, d2, d1, d0}, 6'b100000);
        else n_pass++;
        step_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = sb_a.pop_front();
        n_checks++;
        if (obs_a() !== exp) $display("FAIL rst_after got=%h exp=%h", obs_a(), exp);
        else n_pass++;
    endtask

    task automatic test_invalid_code();
        logic [37:0] exp;
        for (int i = 0; i < 10; i++) begin
            step_a(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            exp = sb_a.pop_front();
            n_checks++;
            if (obs_a() !== exp || {d3, d2, d1, d0, out_valid} !== 5'b0)
                $display("FAIL invalid[%0d] got=%h exp=%h", i, obs_a(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        logic [CW_B-1:0] e;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_s = 1'b1; b_s = 1'b1; v_s = 1'b1; clr_s = 1'b0;
            sb_b.push_back((k < 3) ? CW_B'(k + 1) : CW_B'(3));
            @(posedge clk);
            #1;
            e = sb_b.pop_front();
            n_checks++;
            if ({in_ready_s, out_valid_s, d3_s, d2_s, d1_s, d0_s, cnt3_s} !== {6'b011000, e})
                $display("FAIL sat_pulse[%0d] got=%b exp=%b", k,
                         {in_ready_s, out_valid_s, d3_s, d2_s, d1_s, d0_s, cnt3_s}, {6'b011000, e});
            else n_pass++;
            @(posedge clk);
            #1;
            n_checks++;
            if ({in_ready_s, out_valid_s, d3_s, cnt3_s, cnt2_s, cnt1_s, cnt0_s} !== {3'b100, e, 6'd0})
                $display("FAIL sat_gap[%0d] got=%b exp=%b", k,
                         {in_ready_s, out_valid_s, d3_s, cnt3_s, cnt2_s, cnt1_s, cnt0_s}, {3'b100, e, 6'd0});
            else n_pass++;
        end
        @(negedge clk);
        v_s = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0; v = 1'b0; clr_cnt = 1'b0;
        rst_s = 1'b1; a_s = 1'b0; b_s = 1'b0; v_s = 1'b0; clr_s = 1'b0;
        test_reset();
        test_single_decode();
        test_back_to_back();
        test_clear_priority();
        test_invalid_code();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
